// File: rtl/uart_shift_reg.sv
// Serial/parallel shift register with a frame bit counter for the UART datapath.
// Loading par_in starts a TX frame; shifting from idle starts an RX frame.
// done pulses for one cycle after the DW-th shift of a frame.
module uart_shift_reg #(
   parameter int unsigned DW        = 8,
   parameter bit          LSB_FIRST = 1'b1,
   parameter logic        IDLE_VAL  = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     load,
   input  logic                     enb,
   input  logic [DW-1:0]            par_in,
   input  logic                     ser_in,
   output logic                     ser_out,
   output logic [DW-1:0]            par_out,
   output logic [$clog2(DW+1)-1:0]  bit_cnt,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned CW      = $clog2(DW + 1);
   localparam int unsigned OUT_IDX = LSB_FIRST ? 0 : DW - 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   logic [DW-1:0] data_q, data_d, shifted;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Shifted word: the new serial bit enters at the end opposite the outgoing bit.
   generate
      if (DW == 1) begin : g_single
         assign shifted = ser_in;
      end else if (LSB_FIRST) begin : g_lsb
         assign shifted = {ser_in, data_q[DW-1:1]};
      end else begin : g_msb
         assign shifted = {data_q[DW-2:0], ser_in};
      end
   endgenerate

   // Next state with priority clr > load > enb > hold.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
         busy_d = 1'b0;
      end else if (load) begin
         data_d = par_in;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (enb) begin
         data_d = shifted;
         if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CW'(1);
            busy_d = 1'b1;
         end
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // Serial line shows the outgoing bit during a frame, idle level otherwise.
   assign ser_out = busy_q ? data_q[OUT_IDX] : IDLE_VAL;
   assign par_out = data_q;
   assign bit_cnt = cnt_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_uart_shift_reg.sv
// Self-checking bench for uart_shift_reg: an LSB-first and an MSB-first DW=8
// instance share stimulus and are compared every cycle against a word-level model.
module tb_uart_shift_reg;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       load;
   logic       enb;
   logic [7:0] par_in;
   logic       ser_in;

   logic       so_l, busy_l, done_l;
   logic [7:0] po_l;
   logic [3:0] bc_l;
   logic       so_m, busy_m, done_m;
   logic [7:0] po_m;
   logic [3:0] bc_m;

   int err_cnt = 0;
   int chk_cnt = 0;

   // Reference state per instance: 0 = LSB-first, 1 = MSB-first.
   logic [7:0] m_d    [2];
   int         m_cnt  [2];
   logic       m_busy [2];
   logic       m_done [2];

   uart_shift_reg #(.DW(8), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .enb(enb),
      .par_in(par_in), .ser_in(ser_in), .ser_out(so_l), .par_out(po_l),
      .bit_cnt(bc_l), .busy(busy_l), .done(done_l)
   );

   uart_shift_reg #(.DW(8), .LSB_FIRST(1'b0), .IDLE_VAL(1'b1)) u_msb (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .enb(enb),
      .par_in(par_in), .ser_in(ser_in), .ser_out(so_m), .par_out(po_m),
      .bit_cnt(bc_m), .busy(busy_m), .done(done_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void mdl_reset();
      for (int i = 0; i < 2; i++) begin
         m_d[i]    = 8'h00;
         m_cnt[i]  = 0;
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
      end
   endfunction

   // One clock edge of the frame rules, using the inputs present at that edge.
   function automatic void mdl_edge();
      for (int i = 0; i < 2; i++) begin
         if (clr) begin
            m_d[i] = 8'h00; m_cnt[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
         end else if (load) begin
            m_d[i] = par_in; m_cnt[i] = 0; m_busy[i] = 1'b1; m_done[i] = 1'b0;
         end else if (enb) begin
            if (i == 0) m_d[i] = 8'((m_d[i] >> 1) | (8'(ser_in) << 7));
            else        m_d[i] = 8'((m_d[i] << 1) | 8'(ser_in));
            m_busy[i] = 1'b1;
            if (m_cnt[i] == 7) begin
               m_cnt[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b1;
            end else begin
               m_cnt[i] = m_cnt[i] + 1; m_done[i] = 1'b0;
            end
         end else begin
            m_done[i] = 1'b0;
         end
      end
   endfunction

   function automatic logic mdl_ser(input int i);
      logic [7:0] w;
      w = m_d[i];
      if (!m_busy[i]) return 1'b1;
      return (i == 0) ? w[0] : w[7];
   endfunction

   task automatic check_all();
      check("ser_out_lsb", 32'(so_l),   32'(mdl_ser(0)));
      check("par_out_lsb", 32'(po_l),   32'(m_d[0]));
      check("bit_cnt_lsb", 32'(bc_l),   32'(m_cnt[0]));
      check("busy_lsb",    32'(busy_l), 32'(m_busy[0]));
      check("done_lsb",    32'(done_l), 32'(m_done[0]));
      check("ser_out_msb", 32'(so_m),   32'(mdl_ser(1)));
      check("par_out_msb", 32'(po_m),   32'(m_d[1]));
      check("bit_cnt_msb", 32'(bc_m),   32'(m_cnt[1]));
      check("busy_msb",    32'(busy_m), 32'(m_busy[1]));
      check("done_msb",    32'(done_m), 32'(m_done[1]));
   endtask

   // Advance one edge, update the model, and compare just after the edge.
   task automatic step();
      @(posedge clk);
      mdl_edge();
      #1;
      check_all();
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] rx_bits;
      logic [7:0] b2b_a;
      logic [7:0] b2b_b;
      logic       exp_q [$];
      logic       got_q [$];
      int         n_done;
      logic       prev_done;

      rst = 1'b0; clr = 1'b0; load = 1'b0; enb = 1'b0; par_in = 8'h00; ser_in = 1'b0;
      mdl_reset();
      #1;
      check_all();

      // Reset held while inputs toggle.
      repeat (4) begin
         clr = 1'($urandom); load = 1'($urandom); enb = 1'($urandom);
         par_in = 8'($urandom); ser_in = 1'($urandom);
         @(posedge clk);
         #1;
         check_all();
      end
      clr = 1'b0; load = 1'b0; enb = 1'b0; par_in = 8'h00; ser_in = 1'b0;
      rst = 1'b1;
      repeat (3) step();

      // TX LSB-first 0xA5 with continuous enb.
      pat = 8'hA5;
      load = 1'b1; par_in = pat;
      step();
      load = 1'b0;
      check("tx_bit0", 32'(so_l), 32'(pat[0]));
      enb = 1'b1;
      for (int k = 1; k < 8; k++) begin
         step();
         check("tx_bit", 32'(so_l), 32'(pat[k]));
      end
      step();
      check("tx_done", 32'(done_l), 32'd1);
      check("tx_busy", 32'(busy_l), 32'd0);
      check("tx_idle", 32'(so_l), 32'd1);
      enb = 1'b0;
      step();
      check("tx_done_once", 32'(done_l), 32'd0);

      // RX MSB-first from idle.
      clr = 1'b1;
      step();
      clr = 1'b0;
      rx_bits = 8'b1100_1010;
      enb = 1'b1;
      for (int k = 7; k >= 0; k--) begin
         ser_in = rx_bits[k];
         step();
      end
      enb = 1'b0; ser_in = 1'b0;
      check("rx_word", 32'(po_m), 32'hCA);
      check("rx_done", 32'(done_m), 32'd1);
      check("rx_cnt",  32'(bc_m), 32'd0);
      step();

      // Stall of three cycles after bit 4.
      pat = 8'h3C;
      load = 1'b1; par_in = pat;
      step();
      load = 1'b0; enb = 1'b1;
      repeat (4) step();
      enb = 1'b0;
      check("stall_cnt", 32'(bc_l), 32'd4);
      check("stall_bit", 32'(so_l), 32'(pat[4]));
      repeat (3) begin
         step();
         check("stall_hold_cnt", 32'(bc_l), 32'd4);
         check("stall_hold_bit", 32'(so_l), 32'(pat[4]));
      end
      enb = 1'b1;
      repeat (4) step();
      check("stall_done", 32'(done_l), 32'd1);
      enb = 1'b0;
      step();

      // load with enb: no shift.
      load = 1'b1; enb = 1'b1; par_in = 8'h96;
      step();
      load = 1'b0; enb = 1'b0;
      check("ldenb_cnt", 32'(bc_l), 32'd0);
      check("ldenb_par", 32'(po_l), 32'h96);

      // clr with load: clear wins.
      clr = 1'b1; load = 1'b1; par_in = 8'h77;
      step();
      clr = 1'b0; load = 1'b0;
      check("clrld_busy", 32'(busy_l), 32'd0);
      check("clrld_par",  32'(po_l), 32'd0);

      // load on the final shift edge aborts the frame.
      load = 1'b1; par_in = 8'h11;
      step();
      load = 1'b0; enb = 1'b1;
      repeat (7) step();
      load = 1'b1; par_in = 8'h0F;
      step();
      load = 1'b0; enb = 1'b0;
      check("abort_done", 32'(done_l), 32'd0);
      check("abort_par",  32'(po_l), 32'h0F);
      check("abort_cnt",  32'(bc_l), 32'd0);
      step();
      check("abort_no_done", 32'(done_l), 32'd0);

      // Asynchronous reset in the middle of a frame.
      load = 1'b1; par_in = 8'hE7;
      step();
      load = 1'b0; enb = 1'b1;
      repeat (5) step();
      enb = 1'b0;
      check("arst_pre_cnt", 32'(bc_l), 32'd5);
      #3 rst = 1'b0;
      #1;
      mdl_reset();
      check_all();
      check("arst_busy", 32'(busy_l), 32'd0);
      check("arst_ser",  32'(so_l), 32'd1);
      #1 rst = 1'b1;
      step();
      check("arst_no_done", 32'(done_l), 32'd0);

      // Back-to-back frames, second load in the done cycle.
      b2b_a = 8'h55; b2b_b = 8'hAA;
      for (int k = 0; k < 8; k++) exp_q.push_back(b2b_a[k]);
      for (int k = 0; k < 8; k++) exp_q.push_back(b2b_b[k]);
      n_done = 0;
      load = 1'b1; par_in = b2b_a;
      step();
      load = 1'b0;
      if (busy_l) got_q.push_back(so_l);
      enb = 1'b1;
      repeat (8) begin
         step();
         if (busy_l) got_q.push_back(so_l);
         if (done_l) n_done++;
      end
      enb = 1'b0; load = 1'b1; par_in = b2b_b;
      step();
      load = 1'b0;
      if (busy_l) got_q.push_back(so_l);
      enb = 1'b1;
      repeat (8) begin
         step();
         if (busy_l) got_q.push_back(so_l);
         if (done_l) n_done++;
      end
      enb = 1'b0;
      check("b2b_len", 32'(got_q.size()), 32'd16);
      for (int k = 0; k < 16 && k < got_q.size(); k++)
         check("b2b_bit", 32'(got_q[k]), 32'(exp_q[k]));
      check("b2b_dones", 32'(n_done), 32'd2);

      // Randomized traffic against the model.
      prev_done = 1'b0;
      repeat (400) begin
         clr    = ($urandom_range(0, 19) == 0);
         load   = ($urandom_range(0, 11) == 0);
         enb    = ($urandom_range(0, 2) != 0);
         par_in = 8'($urandom);
         ser_in = 1'($urandom);
         step();
         check("done_twice", 32'(prev_done & done_l), 32'd0);
         prev_done = done_l;
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
